// File: rtl/lcd1602_text_ctrl.sv
// HD44780 / LCD1602 8-bit text controller: on-chip character buffer,
// self-running power-up sequence, and frame redraw on request or continuously.
module lcd1602_text_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int EN_SETUP     = 10,
  parameter int EN_HIGH      = 25,
  parameter int CLEAR_STEPS  = 3,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int AUTO_REFRESH = 1,
  parameter int AW           = $clog2(ROWS*COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh,
  output logic          busy,
  output logic          done,
  output logic [7:0]    dat,
  output logic          rs,
  output logic          rw,
  output logic          en
);

  localparam int NCH = ROWS * COLS;
  localparam int TW  = $clog2(TICK_DIV);

  typedef enum logic [2:0] {INIT, IDLE, ADDR, CHAR, CLRWAIT} state_e;

  state_e          state_q, state_d;
  logic            run_q, run_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [7:0]      sub_q, sub_d;
  logic            row_q, row_d;
  logic [5:0]      col_q, col_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      dat_q, dat_d;
  logic [7:0]      buf_q [NCH];

  logic last, req, seq_end, start_fr;

  function automatic logic [7:0] init_cmd(input logic [7:0] i);
    case (i)
      8'd0:    init_cmd = (ROWS == 2) ? 8'h38 : 8'h30;
      8'd1:    init_cmd = 8'h0C;
      8'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) buf_q[i] <= 8'h20;
    end else if (wr_en && (32'(wr_addr) < NCH)) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  assign last = (tick_q == TW'(TICK_DIV - 1));
  assign req  = refresh && (AUTO_REFRESH == 0);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    tick_d   = tick_q;
    sub_d    = sub_q;
    row_d    = row_q;
    col_d    = col_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q;
    rs_d     = rs_q;
    dat_d    = dat_q;
    seq_end  = 1'b0;
    start_fr = 1'b0;
    if (run_q) begin
      tick_d = last ? '0 : tick_q + 1'b1;
      if (req) pend_d = 1'b1;
      if (last) begin
        unique case (state_q)
          INIT: begin
            if (sub_q != 8'd3) begin
              sub_d = sub_q + 8'd1;
              rs_d  = 1'b0;
              dat_d = init_cmd(sub_q + 8'd1);
            end else if (CLEAR_STEPS > 1) begin
              state_d = CLRWAIT;
              sub_d   = 8'd1;
            end else begin
              seq_end = 1'b1;
            end
          end
          CLRWAIT: begin
            if (sub_q != 8'(CLEAR_STEPS - 1)) sub_d = sub_q + 8'd1;
            else seq_end = 1'b1;
          end
          ADDR: begin
            state_d = CHAR;
            col_d   = '0;
            rs_d    = 1'b1;
            dat_d   = buf_q[ptr_q];
          end
          CHAR: begin
            if (col_q != 6'(COLS - 1)) begin
              col_d = col_q + 6'd1;
              ptr_d = ptr_q + AW'(1);
              rs_d  = 1'b1;
              dat_d = buf_q[ptr_q + AW'(1)];
            end else if (row_q == 1'b0 && ROWS == 2) begin
              state_d = ADDR;
              row_d   = 1'b1;
              ptr_d   = ptr_q + AW'(1);
              rs_d    = 1'b0;
              dat_d   = 8'hC0;
            end else begin
              seq_end = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == INIT) begin
      run_d  = 1'b1;
      tick_d = '0;
      sub_d  = 8'd0;
      rs_d   = 1'b0;
      dat_d  = init_cmd(8'd0);
    end else if (req) begin
      start_fr = 1'b1;
    end
    // A refresh seen on the very last cycle collapses into the pending frame
    if (seq_end && (AUTO_REFRESH != 0 || pend_d)) start_fr = 1'b1;
    if (start_fr) begin
      state_d = ADDR;
      run_d   = 1'b1;
      tick_d  = '0;
      row_d   = 1'b0;
      col_d   = '0;
      ptr_d   = '0;
      pend_d  = 1'b0;
      rs_d    = 1'b0;
      dat_d   = 8'h80;
    end else if (seq_end) begin
      state_d = IDLE;
      run_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
    en_d   = run_d && (state_d != CLRWAIT) &&
             (tick_d >= TW'(EN_SETUP)) &&
             (tick_d < TW'(EN_SETUP + EN_HIGH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      run_q   <= 1'b0;
      tick_q  <= '0;
      sub_q   <= 8'd0;
      row_q   <= 1'b0;
      col_q   <= '0;
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b1;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
      sub_q   <= sub_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
    end
  end

  assign done = run_q && (state_q == CHAR) && last &&
                (row_q == 1'(ROWS - 1)) && (col_q == 6'(COLS - 1));
  assign busy = busy_q;
  assign dat  = dat_q;
  assign rs   = rs_q;
  assign rw   = 1'b0;
  assign en   = en_q;

endmodule
